// File: rtl/step_pattern_player_if.sv
// Bundle between the 29-step one-hot stepper side and the pattern player:
// step/control inputs towards the player, registered status back.
interface step_pattern_player_if #(
  parameter int N_STEPS = 29,
  parameter int FCNT_W  = 8
);
  logic [N_STEPS-1:0] step;
  logic               enable;
  logic [N_STEPS-1:0] pat_in;
  logic               pat_load;
  logic               err_clr;
  logic               pat_bit;
  logic               frame_done;
  logic [FCNT_W-1:0]  frame_cnt;
  logic               pend;
  logic               err;
  logic [1:0]         err_code;

  // Driver of steps and control (stepper / host side).
  modport master (
    output step, enable, pat_in, pat_load, err_clr,
    input  pat_bit, frame_done, frame_cnt, pend, err, err_code
  );

  // The pattern player itself.
  modport slave (
    input  step, enable, pat_in, pat_load, err_clr,
    output pat_bit, frame_done, frame_cnt, pend, err, err_code
  );
endinterface

// File: rtl/step_pattern_player.sv
// Step pattern player: follows a one-hot stepper, checks the step order,
// plays one bit per step from a pattern that is only swapped at frame
// boundaries, counts completed frames and latches sequence errors.
module step_pattern_player #(
  parameter int N_STEPS = 29,
  parameter int FCNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  step_pattern_player_if.slave  bus
);

  localparam int IDX_W = $clog2(N_STEPS);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_ORDER  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_RUN
  } state_t;

  state_t               state_q,      state_d;
  logic [IDX_W-1:0]     prev_idx_q,   prev_idx_d;
  logic [N_STEPS-1:0]   active_q,     active_d;
  logic [N_STEPS-1:0]   pending_q,    pending_d;
  logic                 pend_q,       pend_d;
  logic                 pat_bit_q,    pat_bit_d;
  logic                 frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]    frame_cnt_q,  frame_cnt_d;
  logic                 err_q,        err_d;
  logic [1:0]           err_code_q,   err_code_d;

  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     exp_idx;
  logic                 is_onehot;
  logic                 boundary;
  logic                 accept;

  // Step decode: index of the hot bit (only meaningful when one-hot) and the
  // index the stepper is expected to present next.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_STEPS; i++) begin
      if (bus.step[i]) idx = idx | IDX_W'(i);
    end
    is_onehot = (bus.step != '0) &&
                ((bus.step & (bus.step - N_STEPS'(1))) == '0);
    exp_idx   = (prev_idx_q == IDX_W'(N_STEPS - 1)) ? '0 : prev_idx_q + IDX_W'(1);
  end

  // Next-state logic: sequencing FSM, pattern swap, frame counting, errors.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // forgets one would otherwise infer a latch.
    state_d      = state_q;
    prev_idx_d   = prev_idx_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_d       = pend_q;
    pat_bit_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    err_d        = bus.err_clr ? 1'b0 : err_q;
    err_code_d   = bus.err_clr ? ERR_NONE : err_code_q;
    boundary     = 1'b0;
    accept       = 1'b0;

    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_SYNC;
        S_SYNC: begin
          // Anything other than a clean step 0 is silently skipped here.
          if (bus.step == N_STEPS'(1)) begin
            state_d    = S_RUN;
            prev_idx_d = '0;
            boundary   = 1'b1;
            accept     = 1'b1;
          end
        end
        S_RUN: begin
          if (!is_onehot) begin
            err_d      = 1'b1;
            err_code_d = ERR_ONEHOT;
            state_d    = S_SYNC;
          end else if (idx != exp_idx) begin
            err_d      = 1'b1;
            err_code_d = ERR_ORDER;
            state_d    = S_SYNC;
          end else begin
            prev_idx_d = idx;
            accept     = 1'b1;
            if (idx == '0) begin
              // Legal wrap: both a frame boundary and a completed frame.
              boundary     = 1'b1;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The pending pattern is promoted before step 0's bit is selected, and
    // only the value pending before this cycle is eligible.
    if (boundary && pend_q) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end

    // A load coinciding with a boundary stays pending for the next one.
    if (bus.pat_load) begin
      pending_d = bus.pat_in;
      pend_d    = 1'b1;
    end

    if (accept) pat_bit_d = |(active_d & bus.step);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      prev_idx_q   <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      pat_bit_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      prev_idx_q   <= prev_idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      pat_bit_q    <= pat_bit_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.pat_bit    = pat_bit_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.pend       = pend_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_step_pattern_player.sv
// Randomized scoreboard bench for step_pattern_player: the driver pushes the
// reference model's expected outputs, a monitor pops and compares one entry
// per clock.
module tb_step_pattern_player;

  localparam int N  = 29;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step_pattern_player_if #(.N_STEPS(N), .FCNT_W(FW)) bus ();

  step_pattern_player #(.N_STEPS(N), .FCNT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          pat_bit;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
    logic          pend;
    logic          err;
    logic [1:0]    err_code;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, kept in plain spec terms.
  int           m_mode;     // 0 idle, 1 waiting for step 0, 2 running
  int           m_prev;
  logic [N-1:0] m_active, m_pending;
  bit           m_pend, m_err;
  logic [1:0]   m_code;
  int           m_fcnt;

  int sp;   // position of the healthy stepper

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One clock of stimulus: apply inputs, predict the response, push it.
  task automatic cycle(input logic [N-1:0] st, input bit en, input bit ld,
                       input logic [N-1:0] pat, input bit clr, input bit rs);
    exp_t e;
    int   idx;
    bit   accepted, boundary, complete, new_err;
    logic [1:0] new_code;
    bus.step     = st;
    bus.enable   = en;
    bus.pat_load = ld;
    bus.pat_in   = pat;
    bus.err_clr  = clr;
    rst          = rs;

    idx = 0; accepted = 0; boundary = 0; complete = 0; new_err = 0; new_code = 2'b00;
    e = '0;
    if (rs) begin
      m_mode = 0; m_prev = 0; m_active = '0; m_pending = '0;
      m_pend = 0; m_err = 0; m_code = 2'b00; m_fcnt = 0;
    end else begin
      if (!en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (st == N'(1)) begin
          accepted = 1; boundary = 1; m_mode = 2; m_prev = 0; idx = 0;
        end
      end else begin
        if ($countones(st) != 1) begin
          new_err = 1; new_code = 2'b01; m_mode = 1;
        end else begin
          for (int i = 0; i < N; i++) if (st[i]) idx = i;
          if (idx != (m_prev + 1) % N) begin
            new_err = 1; new_code = 2'b10; m_mode = 1;
          end else begin
            accepted = 1; m_prev = idx;
            if (idx == 0) begin boundary = 1; complete = 1; end
          end
        end
      end
      if (clr) begin m_err = 0; m_code = 2'b00; end
      if (new_err) begin m_err = 1; m_code = new_code; end
      if (boundary && m_pend) begin m_active = m_pending; m_pend = 0; end
      if (ld) begin m_pending = pat; m_pend = 1; end
      if (accepted) e.pat_bit = m_active[idx];
      if (complete) begin m_fcnt = (m_fcnt + 1) % 256; e.frame_done = 1'b1; end
    end
    e.frame_cnt = FW'(m_fcnt);
    e.pend      = m_pend;
    e.err       = m_err;
    e.err_code  = m_code;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic step_legal(input bit ld, input logic [N-1:0] pat, input bit clr);
    cycle(onehot(sp), 1'b1, ld, pat, clr, 1'b0);
    sp = (sp + 1) % N;
  endtask

  task automatic run_legal(input int n);
    for (int i = 0; i < n; i++) step_legal(1'b0, '0, 1'b0);
  endtask

  task automatic run_until(input int pos);
    for (int i = 0; i < 2 * N && sp != pos; i++) step_legal(1'b0, '0, 1'b0);
  endtask

  // Monitor: every clock the DUT presents registered outputs; compare them
  // against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pat_bit",    32'(bus.pat_bit),    32'(e.pat_bit));
        check("frame_done", 32'(bus.frame_done), 32'(e.frame_done));
        check("frame_cnt",  32'(bus.frame_cnt),  32'(e.frame_cnt));
        check("pend",       32'(bus.pend),       32'(e.pend));
        check("err",        32'(bus.err),        32'(e.err));
        check("err_code",   32'(bus.err_code),   32'(e.err_code));
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired queue=%0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    sp = 0;
    // Reset, then a disabled cycle: all outputs must sit at reset values.
    cycle('0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Load 0x5 from a mid-frame stepper position, then three-plus frames.
    sp = 17;
    step_legal(1'b1, N'(32'h5), 1'b0);
    run_legal(4 * N + 5);

    // Not one-hot in RUN, then resync on the following step 0.
    cycle(N'(32'h6), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    run_legal(40);

    // Skipped step 5 -> 7, then clear the error.
    run_until(5);
    step_legal(1'b0, '0, 1'b0);
    sp = 7;
    run_legal(3);
    step_legal(1'b0, '0, 1'b1);
    run_legal(35);

    // Load exactly on a boundary cycle: applies at the following boundary.
    run_until(0);
    step_legal(1'b1, N'($urandom), 1'b0);
    run_legal(2 * N + 3);

    // Enough frames to wrap the frame counter through 255 -> 0.
    run_legal(257 * N);

    // Enable drop keeps state; resume needs a fresh sync.
    for (int i = 0; i < 3; i++) cycle(onehot(sp), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run_legal(40);

    // Random phase: loads, clears, faults and enable drops.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cycle(N'($urandom), 1'b1, ($urandom_range(0, 9) == 0), N'($urandom),
              ($urandom_range(0, 9) == 0), 1'b0);
      end else if (r < 4) begin
        sp = (sp + $urandom_range(2, N - 1)) % N;
        step_legal(1'b0, '0, 1'b0);
      end else if (r < 6) begin
        cycle(onehot(sp), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      end else begin
        step_legal(($urandom_range(0, 14) == 0), N'($urandom),
                   ($urandom_range(0, 29) == 0));
      end
    end

    // Reset in the middle of a frame at step 14, then recover.
    run_legal(2 * N);
    run_until(14);
    cycle(onehot(sp), 1'b1, 1'b1, N'($urandom), 1'b0, 1'b1);
    sp = (sp + 1) % N;
    run_legal(45);

    // Drain the scoreboard.
    cycle('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pattern_player.md
# step_pattern_player

Downstream consumer of the 29-step one-hot stepper. Each cycle it samples the 29-bit one-hot step vector, checks that the sequence is legal (exactly one hot bit, advancing 0..28 and wrapping to 0), and drives one output pin from a programmable 29-bit pattern indexed by the active step. A pattern loaded mid-frame waits in a pending register and takes effect only at the next frame boundary. The block also counts completed frames and latches sequence errors for status readout.

## Interface
- N_STEPS, 29: number of steps per frame; also the width of the step and pattern vectors.
- FCNT_W, 8: width of the frame counter.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- step  in  N_STEPS  one-hot step vector from the stepper.
- enable  in  1  run enable.
- pat_in  in  N_STEPS  new pattern; bit i is the output value for step i.
- pat_load  in  1  single-cycle strobe that captures pat_in into the pending register.
- err_clr  in  1  clears the sticky error flag and error code.
- pat_bit  out  1  registered pattern output.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_cnt  out  FCNT_W  count of completed frames; wraps.
- pend  out  1  a pending pattern is waiting for a frame boundary.
- err  out  1  sticky sequence-error flag.
- err_code  out  2  01 = step not one-hot; 10 = bad step order; 00 = no error.

## Operation
- FSM states are IDLE, SYNC and RUN. Reset enters IDLE.
- IDLE:
  - Entered from any state on the cycle after enable is sampled low.
  - Step input is ignored; pat_bit = 0.
  - When enable is high, moves to SYNC.
- SYNC:
  - Waits for step == 1 (only bit 0 set). All other values, including illegal ones, are ignored without flagging an error.
  - On step == 1, moves to RUN; that step is treated as a frame start.
- RUN:
  - Decodes index idx from step and stores prev_idx.
  - Expected index is prev_idx+1, or 0 when prev_idx == 28.
  - Step not one-hot (zero bits or more than one bit set): err = 1, err_code = 01, go to SYNC.
  - One-hot but idx != expected: err = 1, err_code = 10, go to SYNC.
- Frame boundary:
  - Occurs when idx == 0 is accepted, either on the SYNC->RUN transition or by a legal 28->0 wrap in RUN.
  - If pend = 1 at the boundary, the pending pattern is copied to the active pattern before the bit for step 0 is selected, and pend is cleared.
- Frame completion:
  - Only a legal 28->0 wrap in RUN counts as a completed frame.
  - On completion, frame_cnt increments modulo 2^FCNT_W and frame_done pulses.
- Pattern output: pat_bit = |(active_pat & step) for every accepted step. Cycles in IDLE or SYNC and error cycles drive 0.
- pat_load:
  - Writes the pending register and sets pend.
  - A second load before the boundary overwrites the first; latest value wins.
  - A load on the same cycle as a boundary is not applied at that boundary. It stays pending for the next one.
- err_clr: clears err and err_code. If a new error is detected in the same cycle, the new error wins.
- Dropping enable keeps frame_cnt, the active pattern, the pending register and the error state unchanged.

## Timing
- All outputs are registered. pat_bit, frame_done and err reflect the step sampled at cycle t during cycle t+1.
- Reset values (any cycle, including mid-frame):
  - state = IDLE.
  - pat_bit = 0, frame_done = 0, frame_cnt = 0, pend = 0, err = 0, err_code = 00.
  - Active and pending patterns are cleared to 0.
- Reset has priority over all other inputs.
- After an error, RUN is re-entered at the earliest on the first step == 1 sampled in SYNC. With a healthy stepper this is at most 29 cycles later.
- frame_cnt wraps from 255 to 0 with a normal frame_done pulse.
- frame_done never pulses on the first frame start after SYNC.

## Test plan
- Legal sequence, load: after reset, load pat_in = 0x0000_0005 and hold enable = 1 while driving a legal step sequence. Required: pattern applied at the first step-0 boundary; pat_bit = 1 one cycle after steps 0 and 2 only; pend clears at that boundary.
- Frame counting: 3 full frames after sync. Required: frame_done pulses exactly twice (wrap after frames 1 and 2), then a third time on the next 28->0 wrap; frame_cnt = 3.
- Illegal step value: force step = 0x0000_0006 in RUN. Required: next cycle err = 1, err_code = 01, pat_bit = 0; block resyncs on the next step 0.
- Skipped step: jump from step 5 to step 7. Required: err_code = 10. Then assert err_clr. Required: err = 0, err_code = 00 next cycle.
- Load timing and wrap:
  - Assert pat_load on the boundary cycle. Required: old pattern is used for that frame; new pattern is applied at the following boundary.
  - Preload frame_cnt to 255 and complete a frame. Required: frame_cnt = 0 with a frame_done pulse.
- Reset mid-frame at step 14. Required: all outputs zero the next cycle; the block waits in IDLE/SYNC until step 0 is sampled.
